// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 chip I/O sequencer.
package sha256_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int BLOCK_W     = 8 * BLOCK_BYTES;
    localparam int DIGEST_BITS = 256;
    localparam int OUT_W       = 4;
    localparam int BEATS       = DIGEST_BITS / OUT_W;
    localparam int CNT_W       = $clog2(BLOCK_BYTES);
    localparam int BEAT_W      = $clog2(BEATS);

    typedef logic [CNT_W-1:0]  byte_cnt_t;
    typedef logic [BEAT_W-1:0] beat_cnt_t;

    localparam byte_cnt_t LAST_BYTE = byte_cnt_t'(BLOCK_BYTES - 1);
    localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BEATS - 1);

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    // Bit offset of byte idx inside the block; byte 0 lands in the top byte.
    function automatic logic [CNT_W+2:0] byte_lsb(byte_cnt_t idx);
        return {LAST_BYTE - idx, 3'b000};
    endfunction

endpackage

// File: rtl/sha256_io_ctrl_if.sv
// Chip-side byte interface and core-side command interface of the sequencer.
interface sha256_io_ctrl_if;
    import sha256_pkg::*;

    // chip side
    logic                   write_enable;
    logic [7:0]             data;
    logic                   first_block;
    logic                   last_block;
    logic                   busy;
    logic [OUT_W-1:0]       digest;
    logic                   output_valid;

    // compression core side
    logic                   core_init;
    logic                   core_next;
    logic [BLOCK_W-1:0]     core_block;
    logic                   core_ready;
    logic [DIGEST_BITS-1:0] core_digest;

    // host + core environment
    modport master (
        output write_enable, data, first_block, last_block, core_ready, core_digest,
        input  busy, digest, output_valid, core_init, core_next, core_block
    );

    // the sequencer
    modport slave (
        input  write_enable, data, first_block, last_block, core_ready, core_digest,
        output busy, digest, output_valid, core_init, core_next, core_block
    );

endinterface

// File: rtl/sha256_digest_serializer.sv
// Loads the core hash state in parallel and shifts it out a nibble per cycle,
// most-significant nibble first, with a valid strobe for exactly BEATS cycles.
module sha256_digest_serializer
    import sha256_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [DIGEST_BITS-1:0] din,
    output logic                   valid,
    output logic [OUT_W-1:0]       dout,
    output logic                   done
);

    logic [DIGEST_BITS-1:0] sr_q;
    beat_cnt_t              beat_q;
    logic                   vld_q;

    // shift register, beat counter and valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q   <= '0;
            beat_q <= '0;
            vld_q  <= 1'b0;
        end else if (load) begin
            sr_q   <= din;
            beat_q <= '0;
            vld_q  <= 1'b1;
        end else if (vld_q) begin
            sr_q   <= sr_q << OUT_W;
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT)
                vld_q <= 1'b0;
        end
    end

    // gate the beat so the pins read zero whenever nothing is being streamed
    assign valid = vld_q;
    assign dout  = vld_q ? sr_q[DIGEST_BITS-1 -: OUT_W] : '0;
    assign done  = vld_q && (beat_q == LAST_BEAT);

endmodule

// File: rtl/sha256_io_ctrl.sv
// Sequencer between the byte-wide chip interface and the SHA-256 core:
// packs bytes into a block, commands the core, waits for it, then streams
// the digest after the last block.
module sha256_io_ctrl
    import sha256_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    sha256_io_ctrl_if.slave io
);

    state_t             state_q, state_d;
    byte_cnt_t          byte_cnt_q;
    logic [BLOCK_W-1:0] block_q;
    logic               first_q;
    logic               last_q;
    logic               wait_armed_q;
    logic               accept;
    logic               ser_load;
    logic               ser_done;

    // bytes are only taken in LOAD; everything else reports busy
    assign accept = io.write_enable && (state_q == LOAD);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // next state, core command pulses, busy and digest load
    always_comb begin
        state_d      = state_q;
        io.busy      = 1'b1;
        io.core_init = 1'b0;
        io.core_next = 1'b0;
        ser_load     = 1'b0;
        unique case (state_q)
            LOAD: begin
                io.busy = 1'b0;
                if (accept && (byte_cnt_q == LAST_BYTE))
                    state_d = ISSUE;
            end
            ISSUE: begin
                if (io.core_ready) begin
                    io.core_init = first_q;
                    io.core_next = !first_q;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // the core may still show ready for one cycle after a command
                if (wait_armed_q && io.core_ready) begin
                    if (last_q) begin
                        ser_load = 1'b1;
                        state_d  = OUT;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            OUT: begin
                if (ser_done)
                    state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // byte packing; flags are only taken from byte 0 of each block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_q <= '0;
            block_q    <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
        end else if (accept) begin
            block_q[byte_lsb(byte_cnt_q) +: 8] <= io.data;
            if (byte_cnt_q == '0) begin
                first_q <= io.first_block;
                last_q  <= io.last_block;
            end
            byte_cnt_q <= (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + 1'b1;
        end
    end

    // low only during the first WAIT cycle, which masks core_ready there
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_armed_q <= 1'b0;
        else
            wait_armed_q <= (state_q == WAIT);
    end

    assign io.core_block = block_q;

    sha256_digest_serializer u_ser (
        .clk   (clk),
        .reset (reset),
        .load  (ser_load),
        .din   (io.core_digest),
        .valid (io.output_valid),
        .dout  (io.digest),
        .done  (ser_done)
    );

endmodule

// File: tb/tb_sha256_io_ctrl.sv
// Scoreboard bench: stimulus queues expected core commands and digest nibbles,
// a core model answers commands with a real SHA-256 compression, and a monitor
// checks the nibble stream.
module tb_sha256_io_ctrl;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic reset;
    sha256_io_ctrl_if io();

    sha256_io_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int ncmd = 0;
    int beats_seen = 0;
    int prompt_cyc = -1;
    int ready_cyc = -1;
    bit stall = 1'b0;
    bit core_idle = 1'b1;
    logic [3:0] exp_nib[$];
    bit         exp_cmd[$];

    assign io.core_ready = core_idle && !stall;

    localparam logic [255:0] IV     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_NIST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // standard SHA-256 padding of a short string into one or two blocks
    task automatic pad_msg(input string s, output logic [511:0] b0, output logic [511:0] b1, output int nb);
        logic [7:0]  by [0:127];
        logic [63:0] bits;
        int len;
        len = s.len();
        for (int i = 0; i < 128; i++) by[i] = 8'h00;
        for (int i = 0; i < len; i++) by[i] = s[i];
        by[len] = 8'h80;
        nb = (len + 9 > 64) ? 2 : 1;
        bits = 64'(len) * 8;
        for (int k = 0; k < 8; k++) by[nb*64-1-k] = bits[8*k +: 8];
        for (int i = 0; i < 64; i++) begin
            b0[511-8*i -: 8] = by[i];
            b1[511-8*i -: 8] = by[64+i];
        end
    endtask

    task automatic push_digest(input logic [255:0] d);
        for (int i = 0; i < 64; i++) exp_nib.push_back(d[255-4*i -: 4]);
    endtask

    // wait until the sequencer accepts bytes again; drops write_enable there
    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (!io.busy) begin
                io.write_enable = 1'b0;
                return;
            end
        end
        n_vec++; n_err++;
        $display("FAIL idle_timeout: busy still %0b after 2000 cycles", io.busy);
    endtask

    task automatic send_block(input logic [511:0] blk, input bit first, input bit last,
                              input bit toggle, input bit hold_ff);
        wait_idle();
        for (int i = 0; i < 64; i++) begin
            io.data         = blk[511-8*i -: 8];
            io.write_enable = 1'b1;
            io.first_block  = (i == 0 || !toggle) ? first : ~first;
            io.last_block   = (i == 0 || !toggle) ? last : ~last;
            @(posedge clk); #1;
        end
        prompt_cyc = stall ? -1 : cyc;
        if (hold_ff) begin
            io.data        = 8'hFF;
            io.first_block = 1'b1;
            io.last_block  = 1'b1;
        end else begin
            io.write_enable = 1'b0;
        end
    endtask

    // core model: checks each command and answers with the compressed state
    initial begin
        logic [255:0] hs;
        bit is_init;
        hs = '0;
        io.core_digest = '0;
        forever begin
            @(negedge clk);
            if (!reset && (io.core_init || io.core_next)) begin
                ncmd++;
                check("cmd_exclusive", io.core_init & io.core_next, 0);
                check("cmd_while_busy", io.busy, 1);
                if (exp_cmd.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_cmd: init=%0b next=%0b with none expected", io.core_init, io.core_next);
                end else begin
                    is_init = exp_cmd.pop_front();
                    check("cmd_kind_init", io.core_init, is_init);
                end
                if (prompt_cyc >= 0) check("cmd_latency", cyc, prompt_cyc);
                hs = compress(io.core_init ? IV : hs, io.core_block);
                @(negedge clk);
                check("cmd_pulse_width", {io.core_init, io.core_next}, 0);
                @(posedge clk); #1 core_idle = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                io.core_digest = hs;
                core_idle      = 1'b1;
                ready_cyc      = cyc;
            end
        end
    end

    // digest monitor
    initial begin
        bit pv;
        logic [3:0] e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (io.output_valid) begin
                if (!pv) check("first_beat_latency", cyc, ready_cyc + 1);
                if (exp_nib.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: got %0h with none expected", io.digest);
                end else begin
                    e = exp_nib.pop_front();
                    check($sformatf("beat_%0d", beats_seen), io.digest, e);
                end
                beats_seen++;
            end else if (pv) begin
                check("digest_zero_after_stream", io.digest, 0);
            end
            pv = io.output_valid;
        end
    end

    // stimulus
    initial begin
        logic [511:0] b0, b1, a0, a1;
        int nb, c0, base;
        bit hit;
        reset = 1'b1;
        io.data = 8'h00; io.write_enable = 1'b0;
        io.first_block = 1'b0; io.last_block = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", io.busy, 0);
        check("reset_output_valid", io.output_valid, 0);
        check("reset_digest", io.digest, 0);
        check("reset_core_init", io.core_init, 0);
        check("reset_core_next", io.core_next, 0);
        check("reset_core_block", io.core_block, 0);
        reset = 1'b0;

        // "abc", single block, junk bytes held during busy
        pad_msg("abc", a0, a1, nb);
        exp_cmd.push_back(1'b1);
        push_digest(D_ABC);
        send_block(a0, 1'b1, 1'b1, 1'b0, 1'b1);

        // two-block NIST message with flags toggled on bytes 1..63
        pad_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", b0, b1, nb);
        exp_cmd.push_back(1'b1);
        exp_cmd.push_back(1'b0);
        push_digest(D_NIST);
        send_block(b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send_block(b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // core not ready for 10 cycles at ISSUE entry
        exp_cmd.push_back(1'b1);
        push_digest(D_ABC);
        wait_idle();
        stall = 1'b1;
        c0 = ncmd;
        send_block(a0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("stall_no_cmd", ncmd, c0);
        stall = 1'b0;
        wait_idle();
        check("stall_one_cmd", ncmd, c0 + 1);

        // reset in the middle of the digest stream
        exp_cmd.push_back(1'b1);
        push_digest(D_ABC);
        base = beats_seen;
        send_block(a0, 1'b1, 1'b1, 1'b0, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(posedge clk); #1;
            if (beats_seen == base + 20) hit = 1'b1;
        end
        check("reached_beat_20", hit, 1);
        reset = 1'b1;
        #1;
        check("midrst_output_valid", io.output_valid, 0);
        check("midrst_busy", io.busy, 0);
        check("midrst_digest", io.digest, 0);
        check("midrst_core_block", io.core_block, 0);
        exp_nib.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        exp_cmd.push_back(1'b1);
        push_digest(D_ABC);
        send_block(a0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle();

        for (int k = 0; k < 200; k++) begin
            if (exp_nib.size() == 0 && exp_cmd.size() == 0) break;
            @(posedge clk);
        end
        check("nibbles_outstanding", exp_nib.size(), 0);
        check("cmds_outstanding", exp_cmd.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
